cnn_infer_ctrl: RTL

CNN_INFER_CTRL -- requirements
Module: cnn_infer_ctrl

---
 rtl/cnn_infer_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/cnn_infer_ctrl.sv
// Inference sequencer: launches one image through the CNN pipeline, waits for the
// class scores with a timeout, then scans them serially for the signed argmax.
module cnn_infer_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int N_CLASS        = 16,
  parameter int W              = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 pic_start,
  input  logic                 net_valid,
  input  logic [N_CLASS*W-1:0] net_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [3:0]           result_class,
  output logic [W-1:0]         result_score,
  output logic [31:0]          latency,
  output logic                 timeout
);

  localparam int IW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CLASS - 1);

  logic [2:0]           state;
  logic [31:0]          wait_cnt;
  logic [N_CLASS*W-1:0] cap_buf;
  logic [IW-1:0]        scan_idx;
  logic [IW-1:0]        run_idx;
  logic signed [W-1:0]  run_max;
  logic signed [W-1:0]  cand;
  logic signed [W-1:0]  best_score;
  logic [IW-1:0]        best_idx;

  assign busy      = (state != S_IDLE);
  assign pic_start = (state == S_LAUNCH);

  // Index 0 seeds the maximum; later scores replace it only when strictly greater.
  always_comb begin
    cand       = cap_buf[scan_idx*W +: W];
    best_score = run_max;
    best_idx   = run_idx;
    if (scan_idx == '0 || cand > run_max) begin
      best_score = cand;
      best_idx   = scan_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      cap_buf      <= '0;
      scan_idx     <= '0;
      run_idx      <= '0;
      run_max      <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_score <= '0;
      latency      <= '0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LAUNCH;
            wait_cnt <= '0;
            timeout  <= 1'b0;
            latency  <= '0;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          // A valid on the final allowed cycle takes priority over the timeout.
          if (net_valid) begin
            cap_buf  <= net_data;
            latency  <= wait_cnt;
            scan_idx <= '0;
            state    <= S_SCAN;
          end else if (wait_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_SCAN: begin
          run_max  <= best_score;
          run_idx  <= best_idx;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) begin
            result_class <= 4'(best_idx);
            result_score <= best_score;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
